// File: rtl/level_pkg.sv
// level_pkg: shared state type, level sizing helper and default widths for the level sequencer
package level_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ARM, PLAY, PASSED, FAILED, DONE} state_t;
  localparam int DEF_SCORE_W = 20;
  localparam int DEF_DATA_W = 9;
  localparam int FLD_X = 0;
  localparam int FLD_Y = 1;
  localparam int FLD_TYPE = 2;
  function automatic int level_words(input int objects_count);
    return objects_count * 3 + 1;
  endfunction
endpackage

// File: rtl/level_rom_loader.sv
// level_rom_loader: walks one level's ROM words, captures object descriptors and the scaled target
module level_rom_loader import level_pkg::*; #(
  parameter int NUM_LEVELS = 4,
  parameter int OBJECTS_COUNT = 20,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SCORE_W = DEF_SCORE_W,
  parameter int TARGET_SCALE = 10,
  localparam int LW = level_words(OBJECTS_COUNT),
  localparam int AW = $clog2(NUM_LEVELS * LW),
  localparam int LIW = NUM_LEVELS > 1 ? $clog2(NUM_LEVELS) : 1
) (
  input  logic clk,
  input  logic resetN,
  input  logic active,
  input  logic [LIW-1:0] levelIndex,
  output logic [AW-1:0] romAddr,
  input  logic [DATA_W-1:0] romData,
  output logic [OBJECTS_COUNT*3*DATA_W-1:0] objData,
  output logic [SCORE_W-1:0] targetScore,
  output logic done
);
  localparam int KW = $clog2(LW + 1);
  localparam int PW = DATA_W + SCORE_W + 32;
  logic [KW-1:0] k, pendIdx;
  logic pendValid;
  logic [PW-1:0] prod;
  assign romAddr = (active && k < KW'(LW)) ? AW'(levelIndex * LW + k) : '0;
  assign done = active && pendValid && pendIdx == KW'(LW - 1);
  assign prod = PW'(romData) * PW'(TARGET_SCALE);
  // address counter plus the one-cycle tag of which word the ROM is returning
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      k <= '0;
      pendIdx <= '0;
      pendValid <= 1'b0;
    end else begin
      pendValid <= active && k < KW'(LW);
      pendIdx <= k;
      k <= !active ? '0 : (k < KW'(LW) ? k + 1'b1 : k);
    end
  // store returned words: objects in order, final word becomes the saturated target
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      objData <= '0;
      targetScore <= '0;
    end else if (active && pendValid) begin
      if (done) targetScore <= (prod > PW'({SCORE_W{1'b1}})) ? '1 : prod[SCORE_W-1:0];
      else objData[pendIdx*DATA_W +: DATA_W] <= romData;
    end
endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: level flow controller owning level load, timer, score and pass/fail sequencing
module level_sequencer import level_pkg::*; #(
  parameter int NUM_LEVELS = 4,
  parameter int OBJECTS_COUNT = 20,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_TIME = 60,
  parameter int TIMER_W = 9,
  parameter int SCORE_W = DEF_SCORE_W,
  parameter int TARGET_SCALE = 10,
  localparam int LW = level_words(OBJECTS_COUNT),
  localparam int AW = $clog2(NUM_LEVELS * LW),
  localparam int LIW = NUM_LEVELS > 1 ? $clog2(NUM_LEVELS) : 1
) (
  input  logic clk,
  input  logic resetN,
  input  logic start,
  input  logic advance,
  input  logic restart,
  input  logic pause,
  input  logic oneSecPulse,
  input  logic scoreValid,
  input  logic [SCORE_W-1:0] scoreAdd,
  input  logic allDestroyed,
  output logic [AW-1:0] romAddr,
  input  logic [DATA_W-1:0] romData,
  output logic [OBJECTS_COUNT*3*DATA_W-1:0] objData,
  output logic objLoadPulse,
  output logic playing,
  output logic [LIW-1:0] levelIndex,
  output logic [TIMER_W-1:0] timer,
  output logic [SCORE_W-1:0] levelScore,
  output logic [SCORE_W-1:0] targetScore,
  output logic stageEnded,
  output logic stagePassed,
  output logic lastLevelEnded
);
  state_t state, nextState;
  logic loadDone, tick, endNow, enterLoad;
  logic [SCORE_W-1:0] addVal, newScore;
  logic [SCORE_W:0] sum;
  assign addVal = scoreValid ? scoreAdd : '0;
  assign sum = {1'b0, levelScore} + {1'b0, addVal};
  assign newScore = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  assign tick = oneSecPulse && !pause;
  assign endNow = allDestroyed || (tick && timer == TIMER_W'(1));
  assign enterLoad = nextState == LOAD && state != LOAD;
  assign playing = state == PLAY;
  assign objLoadPulse = state == ARM;
  level_rom_loader #(
    .NUM_LEVELS(NUM_LEVELS), .OBJECTS_COUNT(OBJECTS_COUNT), .DATA_W(DATA_W),
    .SCORE_W(SCORE_W), .TARGET_SCALE(TARGET_SCALE)
  ) loader (
    .clk(clk), .resetN(resetN), .active(state == LOAD), .levelIndex(levelIndex),
    .romAddr(romAddr), .romData(romData), .objData(objData),
    .targetScore(targetScore), .done(loadDone)
  );
  // state register
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else state <= nextState;
  // next state: restart overrides every flow event
  always_comb begin
    nextState = state;
    if (restart) nextState = IDLE;
    else
      case (state)
        IDLE:    nextState = start ? LOAD : IDLE;
        LOAD:    nextState = loadDone ? ARM : LOAD;
        ARM:     nextState = PLAY;
        PLAY:    nextState = !endNow ? PLAY : (newScore >= targetScore ? PASSED : FAILED);
        PASSED:  nextState = !advance ? PASSED : (levelIndex == LIW'(NUM_LEVELS - 1) ? DONE : LOAD);
        FAILED:  nextState = start ? LOAD : FAILED;
        default: nextState = state;
      endcase
  end
  // level index, timer, score and end-of-level pulses
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      levelIndex <= '0;
      timer <= TIMER_W'(MAX_TIME);
      levelScore <= '0;
      lastLevelEnded <= 1'b0;
      stageEnded <= 1'b0;
      stagePassed <= 1'b0;
    end else begin
      stageEnded <= state == PLAY && (nextState == PASSED || nextState == FAILED);
      stagePassed <= state == PLAY && nextState == PASSED;
      if (restart) begin
        levelIndex <= '0;
        lastLevelEnded <= 1'b0;
        levelScore <= '0;
        timer <= TIMER_W'(MAX_TIME);
      end else if (enterLoad) begin
        levelScore <= '0;
        timer <= TIMER_W'(MAX_TIME);
        if (state == PASSED) levelIndex <= levelIndex + 1'b1;
      end else if (state == PLAY) begin
        levelScore <= newScore;
        if (tick && timer != '0) timer <= timer - 1'b1;
      end else if (state == PASSED && nextState == DONE) lastLevelEnded <= 1'b1;
    end
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: table-driven load checks, directed flow sequences and randomized play against a score/timer model
module tb_level_sequencer;
  import level_pkg::*;
  localparam int NL = 2, OC = 2, DW = 20, MT = 3, TW = 4, SW = 20, TS = 10;
  localparam int SMAX = (1 << SW) - 1;
  logic clk = 1'b0, resetN = 1'b0;
  logic start = 1'b0, advance = 1'b0, restart = 1'b0, pause = 1'b0;
  logic oneSecPulse = 1'b0, scoreValid = 1'b0, allDestroyed = 1'b0;
  logic [SW-1:0] scoreAdd = '0;
  logic [3:0] romAddr;
  logic [DW-1:0] romData;
  logic [OC*3*DW-1:0] objData;
  logic objLoadPulse, playing, stageEnded, stagePassed, lastLevelEnded;
  logic [0:0] levelIndex;
  logic [TW-1:0] timer;
  logic [SW-1:0] levelScore, targetScore;
  logic [DW-1:0] rom [16];
  int tests = 0, fails = 0;

  typedef struct {
    int unsigned w [7];
    int unsigned target;
  } load_vec_t;
  load_vec_t vecs [4];

  level_sequencer #(
    .NUM_LEVELS(NL), .OBJECTS_COUNT(OC), .DATA_W(DW), .MAX_TIME(MT),
    .TIMER_W(TW), .SCORE_W(SW), .TARGET_SCALE(TS)
  ) dut (
    .clk(clk), .resetN(resetN), .start(start), .advance(advance), .restart(restart),
    .pause(pause), .oneSecPulse(oneSecPulse), .scoreValid(scoreValid), .scoreAdd(scoreAdd),
    .allDestroyed(allDestroyed), .romAddr(romAddr), .romData(romData), .objData(objData),
    .objLoadPulse(objLoadPulse), .playing(playing), .levelIndex(levelIndex), .timer(timer),
    .levelScore(levelScore), .targetScore(targetScore), .stageEnded(stageEnded),
    .stagePassed(stagePassed), .lastLevelEnded(lastLevelEnded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) romData <= rom[romAddr];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] field(input int slot, input int fld);
    return objData[(slot*3+fld)*DW +: DW];
  endfunction

  task automatic wait_play(output int n);
    n = 0;
    while (!objLoadPulse && n < 40) begin
      step();
      n++;
    end
    step();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic one_sec();
    oneSecPulse = 1'b1;
    step();
    oneSecPulse = 1'b0;
  endtask

  initial begin
    int n, cnt, mTimer;
    longint mScore, nScore, tgt;
    logic tk, ended;
    vecs[0].w = '{10, 20, 1, 30, 40, 2, 5};                 vecs[0].target = 50;
    vecs[1].w = '{0, 0, 0, 0, 0, 0, 0};                     vecs[1].target = 0;
    vecs[2].w = '{1048575, 7, 3, 123456, 99, 1, 104857};    vecs[2].target = 1048570;
    vecs[3].w = '{5, 6, 7, 8, 9, 10, 1048575};              vecs[3].target = SMAX;
    for (int i = 0; i < 16; i++) rom[i] = '0;
    for (int i = 0; i < 7; i++) rom[7+i] = DW'(i + 1);
    rom[13] = DW'(3);
    #12;
    chk("rst_timer", 64'(timer), MT);
    chk("rst_score", 64'(levelScore), 0);
    chk("rst_target", 64'(targetScore), 0);
    chk("rst_objData", 64'(objData != '0), 0);
    chk("rst_outs", 64'({playing, objLoadPulse, stageEnded, stagePassed, lastLevelEnded, levelIndex}), 0);
    chk("rst_romAddr", 64'(romAddr), 0);
    step();
    resetN = 1'b1;
    step();

    for (int v = 0; v < 4; v++) begin
      do_restart();
      for (int i = 0; i < 7; i++) rom[i] = DW'(vecs[v].w[i]);
      pulse_start();
      chk($sformatf("load%0d_addr0", v), 64'(romAddr), 0);
      wait_play(n);
      chk($sformatf("load%0d_cycles", v), n, 8);
      chk($sformatf("load%0d_playing", v), 64'({playing, objLoadPulse}), 64'(2'b10));
      for (int s = 0; s < 2; s++) begin
        chk($sformatf("load%0d_s%0d_x", v, s), 64'(field(s, FLD_X)), vecs[v].w[s*3]);
        chk($sformatf("load%0d_s%0d_y", v, s), 64'(field(s, FLD_Y)), vecs[v].w[s*3+1]);
        chk($sformatf("load%0d_s%0d_t", v, s), 64'(field(s, FLD_TYPE)), vecs[v].w[s*3+2]);
      end
      chk($sformatf("load%0d_target", v), 64'(targetScore), vecs[v].target);
    end

    do_restart();
    for (int i = 0; i < 7; i++) rom[i] = DW'(vecs[0].w[i]);
    pulse_start();
    wait_play(n);
    chk("tmr_start", 64'(timer), 3);
    pause = 1'b1;
    for (int i = 0; i < 2; i++) begin
      one_sec();
      step();
      chk($sformatf("tmr_paused%0d", i), 64'(timer), 3);
    end
    pause = 1'b0;
    one_sec();
    chk("tmr_2", 64'({timer, stageEnded}), 64'({4'd2, 1'b0}));
    step();
    one_sec();
    chk("tmr_1", 64'({timer, stageEnded}), 64'({4'd1, 1'b0}));
    step();
    one_sec();
    chk("tmr_0", 64'(timer), 0);
    chk("tmr_end", 64'({stageEnded, stagePassed}), 64'(2'b10));
    step();
    chk("tmr_end_once", 64'({stageEnded, stagePassed, playing}), 0);
    one_sec();
    chk("tmr_hold_failed", 64'(timer), 0);

    pulse_start();
    chk("retry_level", 64'({romAddr, levelIndex}), 0);
    wait_play(n);
    chk("retry_cycles", n, 8);
    chk("retry_clears", 64'({timer, levelScore}), 64'({4'd3, 20'd0}));
    scoreValid = 1'b1;
    scoreAdd = 30;
    step();
    scoreAdd = 20;
    step();
    scoreValid = 1'b0;
    chk("pass_score", 64'(levelScore), 50);
    chk("pass_no_end_yet", 64'(stageEnded), 0);
    allDestroyed = 1'b1;
    step();
    allDestroyed = 1'b0;
    chk("pass_pulses", 64'({stageEnded, stagePassed}), 64'(2'b11));
    step();
    chk("pass_pulses_once", 64'({stageEnded, stagePassed, playing}), 0);
    scoreValid = 1'b1;
    scoreAdd = 7;
    step();
    scoreValid = 1'b0;
    chk("score_dropped_outside_play", 64'(levelScore), 50);
    pulse_start();
    chk("passed_ignores_start", 64'({levelIndex, playing, romAddr}), 0);

    advance = 1'b1;
    step();
    advance = 1'b0;
    chk("adv_level1", 64'(levelIndex), 1);
    chk("adv_base7", 64'(romAddr), 7);
    wait_play(n);
    chk("lvl1_cycles", n, 8);
    chk("lvl1_target", 64'(targetScore), 30);
    chk("lvl1_obj", 64'({field(0, FLD_X), field(1, FLD_TYPE)}), 64'({20'd1, 20'd6}));
    allDestroyed = 1'b1;
    step();
    allDestroyed = 1'b0;
    chk("lvl1_fail", 64'({stageEnded, stagePassed}), 64'(2'b10));
    pulse_start();
    chk("lvl1_retry_base", 64'(romAddr), 7);
    wait_play(n);
    scoreValid = 1'b1;
    scoreAdd = 30;
    allDestroyed = 1'b1;
    step();
    scoreValid = 1'b0;
    allDestroyed = 1'b0;
    chk("lvl1_same_cycle_pass", 64'({stageEnded, stagePassed, levelScore}), 64'({2'b11, 20'd30}));
    chk("lvl1_not_last_yet", 64'(lastLevelEnded), 0);
    advance = 1'b1;
    step();
    advance = 1'b0;
    chk("done_last", 64'(lastLevelEnded), 1);
    step();
    pulse_start();
    advance = 1'b1;
    step();
    advance = 1'b0;
    step();
    chk("done_sticky", 64'({lastLevelEnded, levelIndex, playing}), 64'(3'b110));
    do_restart();
    chk("restart_clears", 64'({lastLevelEnded, levelIndex, timer, levelScore}), 64'({1'b0, 1'b0, 4'd3, 20'd0}));
    chk("restart_keeps_obj", 64'(field(0, FLD_X)), 1);

    rom[6] = DW'(104858);
    pulse_start();
    wait_play(n);
    chk("sat_target", 64'(targetScore), SMAX);
    scoreValid = 1'b1;
    scoreAdd = SW'(SMAX - 4);
    step();
    chk("sat_pre", 64'(levelScore), SMAX - 4);
    scoreAdd = 100;
    allDestroyed = 1'b1;
    step();
    scoreValid = 1'b0;
    allDestroyed = 1'b0;
    chk("sat_score", 64'(levelScore), SMAX);
    chk("sat_pass", 64'({stageEnded, stagePassed}), 64'(2'b11));

    do_restart();
    pulse_start();
    for (int i = 0; i < 4; i++) step();
    chk("midload_k4", 64'(romAddr), 4);
    do_restart();
    chk("midload_idle", 64'({levelIndex, romAddr, playing}), 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (objLoadPulse || playing) cnt++;
    end
    chk("midload_no_pulse", cnt, 0);

    for (int r = 0; r < 25; r++) begin
      do_restart();
      rom[6] = DW'($urandom_range(0, 8));
      tgt = longint'(rom[6]) * TS;
      pulse_start();
      wait_play(n);
      chk($sformatf("rnd%0d_target", r), 64'(targetScore), 64'(tgt));
      mTimer = MT;
      mScore = 0;
      for (int c = 0; c < 100; c++) begin
        scoreValid = 1'($urandom_range(0, 1));
        scoreAdd = SW'($urandom_range(0, 15));
        oneSecPulse = ($urandom_range(0, 3) == 0);
        pause = ($urandom_range(0, 2) == 0);
        allDestroyed = ($urandom_range(0, 39) == 0);
        nScore = mScore + (scoreValid ? longint'(scoreAdd) : 0);
        if (nScore > SMAX) nScore = SMAX;
        tk = oneSecPulse && !pause;
        ended = allDestroyed || (tk && mTimer == 1);
        step();
        if (tk) mTimer--;
        mScore = nScore;
        chk($sformatf("rnd%0d_c%0d_score", r, c), 64'(levelScore), 64'(mScore));
        chk($sformatf("rnd%0d_c%0d_timer", r, c), 64'(timer), 64'(mTimer));
        chk($sformatf("rnd%0d_c%0d_end", r, c), 64'(stageEnded), 64'(ended));
        if (ended) begin
          chk($sformatf("rnd%0d_pass", r), 64'(stagePassed), 64'(mScore >= tgt));
          break;
        end
      end
      {scoreValid, oneSecPulse, pause, allDestroyed} = '0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
